bf_agu: RTL and testbench

- Address generation unit for the Bellman-Ford relaxation engine. It is the responder to the iteration controller.
- Consumes the controller's read_enable/write_enable strobes and sweeps every (src,dst) edge address of the N x N adjacency matrix, one per cycle.
- Waits out the relaxation datapath latency, then reports iteration_done. It reports finish after N-1 iterations, or earlier when a complete sweep produced no distance update.

---
 rtl/bf_agu.sv | 112 +++++++++++
 tb/tb_bf_agu.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bf_agu.sv
// rtl/bf_agu.sv - Bellman-Ford edge address generator and iteration sequencer
// Sweeps the N x N adjacency matrix once per iteration and decides when the run is finished.
module bf_agu #(
  parameter int N   = 8,
  parameter int AW  = 3,
  parameter int IW  = 4,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst_global_n,
  input  logic          read_enable,
  input  logic          write_enable,
  input  logic          relax_update,
  output logic [AW-1:0] src_addr,
  output logic [AW-1:0] dst_addr,
  output logic          addr_valid,
  output logic          iteration_done,
  output logic          finish,
  output logic [IW-1:0] iter_count
);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_SWEEP, S_DRAIN, S_DONE} state_t;

  state_t        state;
  logic          changed;
  logic [3:0]    drain_cnt;
  logic          changed_next;
  logic          last_addr;
  logic          start_run;
  logic          enter_done;
  logic          finish_next;
  logic [IW-1:0] iter_next;

  // Updates arriving on the cycle that enters DONE still count toward this iteration.
  assign changed_next = changed | relax_update;
  assign last_addr    = (src_addr == AW'(N-1)) && (dst_addr == AW'(N-1));
  assign iter_next    = iter_count + IW'(1);
  assign finish_next  = (iter_next == IW'(N-1)) || !changed_next;
  assign start_run    = (state == S_IDLE) ? read_enable : (read_enable && !write_enable);
  assign enter_done   = ((state == S_SWEEP) && last_addr && (LAT == 0)) ||
                        ((state == S_DRAIN) && (drain_cnt <= 4'd1));

  always_ff @(posedge clk or negedge rst_global_n) begin
    if (!rst_global_n) begin
      state          <= S_IDLE;
      src_addr       <= '0;
      dst_addr       <= '0;
      addr_valid     <= 1'b0;
      iteration_done <= 1'b0;
      finish         <= 1'b0;
      iter_count     <= '0;
      changed        <= 1'b0;
      drain_cnt      <= '0;
    end else if (start_run) begin
      // A read strobe without write outside IDLE is a controller restart.
      state          <= S_ARM;
      src_addr       <= '0;
      dst_addr       <= '0;
      addr_valid     <= 1'b0;
      iteration_done <= 1'b0;
      finish         <= 1'b0;
      iter_count     <= '0;
      changed        <= 1'b0;
      drain_cnt      <= '0;
    end else begin
      case (state)
        S_ARM: begin
          if (!read_enable) begin
            state      <= S_SWEEP;
            addr_valid <= 1'b1;
          end
        end
        S_SWEEP: begin
          changed  <= changed_next;
          dst_addr <= dst_addr + AW'(1);
          if (dst_addr == AW'(N-1)) begin
            src_addr <= src_addr + AW'(1);
          end
          if (last_addr) begin
            addr_valid <= 1'b0;
            state      <= S_DRAIN;
            drain_cnt  <= 4'(LAT);
          end
        end
        S_DRAIN: begin
          changed   <= changed_next;
          drain_cnt <= drain_cnt - 4'd1;
        end
        S_DONE: begin
          if (finish) begin
            state          <= S_IDLE;
            iteration_done <= 1'b0;
          end else if (read_enable && write_enable) begin
            state          <= S_ARM;
            iteration_done <= 1'b0;
            changed        <= 1'b0;
            src_addr       <= '0;
            dst_addr       <= '0;
          end
        end
        default: ;
      endcase
      if (enter_done) begin
        state          <= S_DONE;
        iteration_done <= 1'b1;
        iter_count     <= iter_next;
        finish         <= finish_next;
      end
    end
  end

endmodule

// File: tb/tb_bf_agu.sv
// tb/tb_bf_agu.sv - randomized scoreboard bench for bf_agu
// Expected addresses and iteration results are derived from cycle arithmetic and pulse counts.
module tb_bf_agu;
  localparam int N   = 8;
  localparam int AW  = 3;
  localparam int IW  = 4;
  localparam int LAT = 2;
  localparam int SW  = N * N;

  typedef struct {
    int cyc;
    int a;
    int b;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_global_n = 1'b0;
  logic          read_enable = 1'b0;
  logic          write_enable = 1'b0;
  logic          relax_update = 1'b0;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic          addr_valid;
  logic          iteration_done;
  logic          finish;
  logic [IW-1:0] iter_count;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  bit   prev_done = 1'b0;
  int   model_iter = 0;
  exp_t addr_q[$];
  exp_t done_q[$];
  exp_t mon_e;

  bf_agu #(.N(N), .AW(AW), .IW(IW), .LAT(LAT)) dut (
    .clk            (clk),
    .rst_global_n   (rst_global_n),
    .read_enable    (read_enable),
    .write_enable   (write_enable),
    .relax_update   (relax_update),
    .src_addr       (src_addr),
    .dst_addr       (dst_addr),
    .addr_valid     (addr_valid),
    .iteration_done (iteration_done),
    .finish         (finish),
    .iter_count     (iter_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(1));
  endfunction

  // Inputs set here belong to the cycle that just began.
  task automatic step(input logic re, input logic we, input logic ru);
    @(posedge clk);
    #1;
    read_enable  = re;
    write_enable = we;
    relax_update = ru;
  endtask

  always @(negedge clk) begin
    if (mon_en && addr_valid) begin
      check("addr_expected", int'(addr_q.size() != 0), 1);
      if (addr_q.size() != 0) begin
        mon_e = addr_q.pop_front();
        check("addr_cycle", cyc, mon_e.cyc);
        check("src_addr", int'(src_addr), mon_e.a);
        check("dst_addr", int'(dst_addr), mon_e.b);
      end
    end
    if (mon_en && iteration_done && !prev_done) begin
      check("done_expected", int'(done_q.size() != 0), 1);
      if (done_q.size() != 0) begin
        mon_e = done_q.pop_front();
        check("done_cycle", cyc, mon_e.cyc);
        check("done_iter_count", int'(iter_count), mon_e.a);
        check("done_finish", int'(finish), mon_e.b);
      end
    end
    prev_done = iteration_done;
  end

  task automatic start_run(output int b);
    step(1'b1, 1'b0, rbit());
    step(1'b1, 1'b0, rbit());
    step(1'b0, 1'b0, rbit());
    b = cyc + 1;
    model_iter = 0;
  endtask

  task automatic commit(output int b);
    step(1'b1, 1'b1, rbit());
    step(1'b0, 1'b0, rbit());
    b = cyc + 1;
  endtask

  // mode 0: random updates (at least one), 1: none, 2: only on the final drain cycle
  task automatic sweep(input int b, input int mode, input bit abort);
    logic plan [SW+16];
    int   pulses = 0;
    int   n;
    bit   fin;
    for (int i = 0; i < SW + LAT; i++) begin
      case (mode)
        0:       plan[i] = ($urandom_range(7) == 0) || (i == N);
        1:       plan[i] = 1'b0;
        default: plan[i] = (i == SW + LAT - 1);
      endcase
      if (plan[i]) pulses++;
    end
    for (int k = 0; k < SW; k++) addr_q.push_back('{b + k, k / N, k % N});
    if (!abort) begin
      model_iter++;
      fin = (model_iter == N - 1) || (pulses == 0);
      done_q.push_back('{b + SW + LAT, model_iter, int'(fin)});
    end
    n = abort ? SW : SW + LAT;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, plan[i]);
  endtask

  task automatic finish_tail();
    step(1'b0, 1'b0, rbit());
    step(1'b0, 1'b0, 1'b0);
    check("done_cleared", int'(iteration_done), 0);
    check("finish_sticky", int'(finish), 1);
    check("iter_hold", int'(iter_count), model_iter);
    repeat (5) step(1'b0, 1'b0, rbit());
    check("idle_no_addr", int'(addr_valid), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    repeat (3) step(1'b0, 1'b0, 1'b0);
    check("rst_addr_valid", int'(addr_valid), 0);
    check("rst_done", int'(iteration_done), 0);
    check("rst_finish", int'(finish), 0);
    check("rst_iter", int'(iter_count), 0);
    check("rst_src", int'(src_addr), 0);
    check("rst_dst", int'(dst_addr), 0);
    rst_global_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;

    // Full run terminating on the iteration limit.
    start_run(b);
    for (int s = 1; s <= N - 1; s++) begin
      sweep(b, 0, 1'b0);
      if (s < N - 1) commit(b);
    end
    finish_tail();

    // Late update keeps the run going, then a quiet sweep ends it early.
    start_run(b);
    sweep(b, 0, 1'b0);
    commit(b);
    sweep(b, 2, 1'b0);
    commit(b);
    sweep(b, 1, 1'b0);
    finish_tail();

    // Restart from DRAIN at iter_count 4.
    start_run(b);
    for (int s = 1; s <= 4; s++) begin
      sweep(b, 0, 1'b0);
      commit(b);
    end
    sweep(b, 0, 1'b1);
    check("pre_restart_iter", int'(iter_count), 4);
    step(1'b1, 1'b0, rbit());
    step(1'b1, 1'b0, rbit());
    check("restart_iter", int'(iter_count), 0);
    check("restart_finish", int'(finish), 0);
    check("restart_valid", int'(addr_valid), 0);
    check("restart_done", int'(iteration_done), 0);
    step(1'b0, 1'b0, rbit());
    b = cyc + 1;
    model_iter = 0;
    sweep(b, 0, 1'b0);
    commit(b);
    sweep(b, 1, 1'b0);
    finish_tail();

    // Asynchronous reset in the middle of a sweep.
    mon_en = 1'b0;
    start_run(b);
    repeat (20) step(1'b0, 1'b0, rbit());
    check("mid_sweep_valid", int'(addr_valid), 1);
    #2;
    rst_global_n = 1'b0;
    #1;
    check("async_rst_valid", int'(addr_valid), 0);
    check("async_rst_src", int'(src_addr), 0);
    check("async_rst_dst", int'(dst_addr), 0);
    check("async_rst_iter", int'(iter_count), 0);
    check("async_rst_done", int'(iteration_done), 0);
    check("async_rst_finish", int'(finish), 0);
    step(1'b0, 1'b0, 1'b0);
    rst_global_n = 1'b1;
    repeat (3) step(1'b0, 1'b0, rbit());
    check("post_rst_valid", int'(addr_valid), 0);
    check("post_rst_src", int'(src_addr), 0);
    check("post_rst_dst", int'(dst_addr), 0);
    mon_en = 1'b1;

    // A first sweep without updates finishes at once.
    start_run(b);
    sweep(b, 1, 1'b0);
    finish_tail();

    check("addr_q_drained", addr_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
